// File: rtl/matrix_input_serializer_pkg.sv
// Shared constants and state type for the matrix input serializer.
package matrix_input_pkg;

    localparam int unsigned DATA_W = 16;
    localparam int unsigned N      = 4;
    localparam int unsigned NN     = N * N;
    localparam int unsigned IDX_W  = $clog2(NN);
    localparam int unsigned SUM_W  = DATA_W + IDX_W;

    typedef enum logic {
        IDLE,
        STREAM
    } state_t;

endpackage

// File: rtl/matrix_input_serializer_order_index.sv
// Maps the beat counter to a buffer index for row-major or column-major readout.
module matrix_order_index
    import matrix_input_pkg::*;
(
    input  logic [IDX_W-1:0] beat_i,
    input  logic             transpose_i,
    output logic [IDX_W-1:0] idx_o
);

    always_comb begin
        idx_o = beat_i;
        if (transpose_i) begin
            // beat c walks column c/N... reading element (row = c mod N, col = c / N)
            idx_o = IDX_W'((beat_i % IDX_W'(N)) * IDX_W'(N) + beat_i / IDX_W'(N));
        end
    end

endmodule

// File: rtl/matrix_input_serializer.sv
// Captures a 4x4 matrix in one transfer and streams it out one word per beat,
// with a running checksum that is qualified after the final word.
module matrix_input_serializer
    import matrix_input_pkg::*;
(
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [NN*DATA_W-1:0] matrix_input,
    input  logic                 transpose,
    output logic [DATA_W-1:0]    matrix_output,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic                 out_last,
    output logic [IDX_W-1:0]     out_index,
    output logic [SUM_W-1:0]     checksum,
    output logic                 checksum_valid
);

    state_t              state_q, state_d;
    logic [IDX_W-1:0]    cnt_q, cnt_d;
    logic [SUM_W-1:0]    acc_q, acc_d;
    logic                tr_q, tr_d;
    logic                csv_q, csv_d;
    logic                load;
    logic [DATA_W-1:0]   buf_q [NN];
    logic [IDX_W-1:0]    buf_idx;
    logic [DATA_W-1:0]   cur_word;

    matrix_order_index u_order (
        .beat_i      (cnt_q),
        .transpose_i (tr_q),
        .idx_o       (buf_idx)
    );

    assign cur_word = buf_q[buf_idx];

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        acc_d   = acc_q;
        tr_d    = tr_q;
        csv_d   = 1'b0;
        load    = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (in_valid) begin
                    state_d = STREAM;
                    load    = 1'b1;
                    cnt_d   = '0;
                    acc_d   = '0;
                    tr_d    = transpose;
                end
            end
            STREAM: begin
                if (out_ready) begin
                    acc_d = acc_q + SUM_W'(cur_word);
                    // counter wraps to 0 on the last beat, so IDLE shows index 0
                    cnt_d = cnt_q + IDX_W'(1);
                    if (cnt_q == IDX_W'(NN - 1)) begin
                        state_d = IDLE;
                        csv_d   = 1'b1;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            acc_q   <= '0;
            tr_q    <= 1'b0;
            csv_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            acc_q   <= acc_d;
            tr_q    <= tr_d;
            csv_q   <= csv_d;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int unsigned i = 0; i < NN; i++) begin
                buf_q[i] <= '0;
            end
        end else if (load) begin
            for (int unsigned i = 0; i < NN; i++) begin
                buf_q[i] <= matrix_input[i*DATA_W +: DATA_W];
            end
        end
    end

    // checksum tracks the accumulator; it is final once checksum_valid pulses
    assign in_ready       = (state_q == IDLE);
    assign out_valid      = (state_q == STREAM);
    assign out_last       = (state_q == STREAM) && (cnt_q == IDX_W'(NN - 1));
    assign out_index      = cnt_q;
    assign matrix_output  = cur_word;
    assign checksum       = acc_q;
    assign checksum_valid = csv_q;

endmodule

// File: tb/tb_matrix_input_serializer.sv
// Randomized self-checking bench for matrix_input_serializer against a
// row/column traversal reference model.
module tb_matrix_input_serializer;

    logic         clk;
    logic         rst_n;
    logic         in_valid;
    logic         in_ready;
    logic [255:0] matrix_input;
    logic         transpose;
    logic [15:0]  matrix_output;
    logic         out_valid;
    logic         out_ready;
    logic         out_last;
    logic [3:0]   out_index;
    logic [19:0]  checksum;
    logic         checksum_valid;

    matrix_input_serializer dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .in_valid       (in_valid),
        .in_ready       (in_ready),
        .matrix_input   (matrix_input),
        .transpose      (transpose),
        .matrix_output  (matrix_output),
        .out_valid      (out_valid),
        .out_ready      (out_ready),
        .out_last       (out_last),
        .out_index      (out_index),
        .checksum       (checksum),
        .checksum_valid (checksum_valid)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    logic [15:0] mat  [16];
    logic [15:0] matb [16];
    logic [15:0] exp_w[16];
    logic [19:0] exp_sum;
    bit          tr_cur;
    bit          tr_b;
    int          cycles;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Reference: walk the matrix by rows, or by columns when transposed.
    task automatic build_expected();
        int k;
        k = 0;
        exp_sum = '0;
        if (!tr_cur) begin
            for (int r = 0; r < 4; r++)
                for (int c = 0; c < 4; c++) begin
                    exp_w[k] = mat[r*4 + c];
                    k = k + 1;
                end
        end else begin
            for (int c = 0; c < 4; c++)
                for (int r = 0; r < 4; r++) begin
                    exp_w[k] = mat[r*4 + c];
                    k = k + 1;
                end
        end
        for (int i = 0; i < 16; i++) exp_sum = exp_sum + 20'(exp_w[i]);
    endtask

    task automatic rand_mat();
        for (int i = 0; i < 16; i++) mat[i] = 16'($urandom);
    endtask

    task automatic load_mat(input bit keep);
        int waitc;
        waitc = 0;
        while (!in_ready && waitc < 40) begin
            @(posedge clk); #1;
            waitc++;
        end
        if (!in_ready) check("in_ready_timeout", {31'd0, in_ready}, 32'd1);
        for (int i = 0; i < 16; i++) matrix_input[i*16 +: 16] = mat[i];
        transpose = tr_cur;
        in_valid  = 1'b1;
        @(posedge clk); #1;
        if (!keep) in_valid = 1'b0;
        build_expected();
    endtask

    // Called 1 time unit after the load edge; returns in the checksum cycle.
    task automatic stream(input int stall_at, input int stall_len, input bit rnd, input bit hold,
                          output int ncyc);
        int c;
        int stalled;
        bit rdy;
        c = 0;
        stalled = 0;
        ncyc = 0;
        while (c < 16 && ncyc < 200) begin
            check("out_valid", {31'd0, out_valid}, 32'd1);
            check("in_ready_busy", {31'd0, in_ready}, 32'd0);
            check("out_index", {28'd0, out_index}, c);
            check("matrix_output", {16'd0, matrix_output}, {16'd0, exp_w[c]});
            check("out_last", {31'd0, out_last}, (c == 15) ? 32'd1 : 32'd0);
            check("csv_busy", {31'd0, checksum_valid}, 32'd0);
            if (c == stall_at && stalled < stall_len) begin
                rdy = 1'b0;
                stalled++;
            end else if (rnd) begin
                rdy = ($urandom_range(0, 3) != 0);
            end else begin
                rdy = 1'b1;
            end
            out_ready = rdy;
            @(posedge clk); #1;
            ncyc++;
            if (rdy) c++;
        end
        if (c < 16) check("stream_timeout", c, 16);
        check("csv_pulse", {31'd0, checksum_valid}, 32'd1);
        check("checksum", {12'd0, checksum}, {12'd0, exp_sum});
        check("out_valid_idle", {31'd0, out_valid}, 32'd0);
        check("out_last_idle", {31'd0, out_last}, 32'd0);
        check("in_ready_idle", {31'd0, in_ready}, 32'd1);
        if (!hold) begin
            @(posedge clk); #1;
            check("csv_drop", {31'd0, checksum_valid}, 32'd0);
            check("checksum_hold", {12'd0, checksum}, {12'd0, exp_sum});
        end
    endtask

    initial begin
        rst_n        = 1'b0;
        in_valid     = 1'b0;
        out_ready    = 1'b0;
        transpose    = 1'b0;
        matrix_input = '0;
        tr_cur       = 1'b0;

        // Held reset: in_valid pulses must be ignored
        for (int i = 0; i < 4; i++) begin
            @(posedge clk); #1;
            in_valid = i[0];
            matrix_input = {8{32'($urandom)}};
            check("rst_in_ready", {31'd0, in_ready}, 32'd1);
            check("rst_out_valid", {31'd0, out_valid}, 32'd0);
            check("rst_out_last", {31'd0, out_last}, 32'd0);
            check("rst_out_index", {28'd0, out_index}, 32'd0);
            check("rst_checksum", {12'd0, checksum}, 32'd0);
            check("rst_csv", {31'd0, checksum_valid}, 32'd0);
            check("rst_data", {16'd0, matrix_output}, 32'd0);
        end
        in_valid = 1'b0;
        rst_n = 1'b1;
        @(posedge clk); #1;
        check("post_rst_in_ready", {31'd0, in_ready}, 32'd1);
        check("post_rst_out_valid", {31'd0, out_valid}, 32'd0);

        // Row-major with k*1111
        for (int i = 0; i < 16; i++) mat[i] = 16'(i * 16'h1111);
        tr_cur = 1'b0;
        load_mat(1'b0);
        stream(-1, 0, 1'b0, 1'b0, cycles);
        check("row_sum_const", {12'd0, checksum}, 32'h7FFF8);
        check("row_cycles", cycles, 16);

        // Transposed, same data
        tr_cur = 1'b1;
        load_mat(1'b0);
        check("tr_beat1", {16'd0, matrix_output}, 32'h0000);
        stream(-1, 0, 1'b0, 1'b0, cycles);
        check("tr_sum_const", {12'd0, checksum}, 32'h7FFF8);

        // Backpressure: 3 stall cycles at beat 5
        tr_cur = 1'b0;
        load_mat(1'b0);
        stream(5, 3, 1'b0, 1'b0, cycles);
        check("bp_cycles", cycles, 19);
        check("bp_sum_const", {12'd0, checksum}, 32'h7FFF8);

        // Load gating: in_valid held high with new data across a stream
        rand_mat();
        tr_cur = 1'($urandom);
        load_mat(1'b1);
        tr_b = 1'($urandom);
        for (int i = 0; i < 16; i++) begin
            matb[i] = 16'($urandom);
            matrix_input[i*16 +: 16] = matb[i];
        end
        transpose = tr_b;
        stream(-1, 0, 1'b1, 1'b1, cycles);
        for (int i = 0; i < 16; i++) mat[i] = matb[i];
        tr_cur = tr_b;
        build_expected();
        @(posedge clk); #1;
        in_valid = 1'b0;
        stream(-1, 0, 1'b0, 1'b0, cycles);

        // Reset mid-stream at beat 7
        rand_mat();
        tr_cur = 1'b1;
        load_mat(1'b0);
        out_ready = 1'b1;
        for (int i = 0; i < 7; i++) @(posedge clk);
        #1;
        check("mid_index", {28'd0, out_index}, 32'd7);
        check("mid_data", {16'd0, matrix_output}, {16'd0, exp_w[7]});
        #2 rst_n = 1'b0;
        #1;
        check("abort_out_valid", {31'd0, out_valid}, 32'd0);
        check("abort_checksum", {12'd0, checksum}, 32'd0);
        check("abort_csv", {31'd0, checksum_valid}, 32'd0);
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            check("abort_no_pulse", {31'd0, checksum_valid}, 32'd0);
            check("abort_out_valid_hold", {31'd0, out_valid}, 32'd0);
        end
        rst_n = 1'b1;
        out_ready = 1'b0;
        @(posedge clk); #1;
        check("abort_in_ready", {31'd0, in_ready}, 32'd1);
        check("abort_index", {28'd0, out_index}, 32'd0);
        rand_mat();
        tr_cur = 1'b0;
        load_mat(1'b0);
        stream(-1, 0, 1'b0, 1'b0, cycles);

        // Randomized matrices, order and backpressure
        for (int n = 0; n < 8; n++) begin
            rand_mat();
            tr_cur = 1'($urandom);
            load_mat(1'b0);
            stream(-1, 0, 1'b1, 1'b0, cycles);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout got=running exp=finished");
        $fatal(1);
    end

endmodule
